// File: rtl/psychic5_objdma_pkg.sv
// Shared state encoding and widths for the Psychic 5 sprite-attribute DMA.
package psychic5_objdma_pkg;

  localparam int OBJDMA_AW = 13;
  localparam int OBJBUF_AW = 9;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ADDR,
    READ,
    DONE
  } objdma_state_t;

endpackage

// File: rtl/psychic5_objdma_buf.sv
// Sprite buffer RAM: one MCLK write port, one registered MCLK read port.
module psychic5_objdma_buf #(
  parameter int AW = 9
) (
  input  logic          i_EMU_MCLK,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge i_EMU_MCLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/psychic5_objdma.sv
// Psychic 5 sprite-attribute DMA: takes the Z80 bus on a frame trigger and snapshots work RAM.
// Define PSYCHIC5_OBJDMA_DBLBUF_EN for a double-buffered (2x512) sprite buffer.
module psychic5_objdma
  import psychic5_objdma_pkg::*;
#(
  parameter logic [OBJDMA_AW-1:0] P_BASE_ADDR = 13'h1000,
  parameter int                   P_LENGTH    = 512
) (
  input  logic                 i_EMU_MCLK,
  input  logic                 i_EMU_MRST_n,
  input  logic                 i_EMU_CLK6MPCEN_n,
  output logic                 o_OBJDMA_BUSRQ_n,
  input  logic                 i_OBJDMA_BUSACK_n,
  output logic [OBJDMA_AW-1:0] o_OBJDMA_ADDR_BUS,
  input  logic [7:0]           i_OBJDMA_DATA_READ_BUS,
  output logic                 o_OBJDMA_CTRL_RD_n,
  output logic                 o_OBJDMA_CTRL_WR_n,
  input  logic                 i_DMA_TRIG,
  input  logic                 i_OBJ_BUF_INIT_STOP_n,
  input  logic [OBJBUF_AW-1:0] i_BUF_RADDR,
  output logic [7:0]           o_BUF_RDATA,
  output logic                 o_DMA_BUSY
);

`ifdef PSYCHIC5_OBJDMA_DBLBUF_EN
  localparam int BUF_AW = OBJBUF_AW + 1;
`else
  localparam int BUF_AW = OBJBUF_AW;
`endif
  localparam logic [OBJBUF_AW-1:0] LAST_IDX = OBJBUF_AW'(P_LENGTH - 1);

  objdma_state_t        state_q, state_d;
  logic                 tick;
  logic                 trig_prev, trig_edge;
  logic                 busrq_n_q, rd_n_q, busy_q;
  logic                 buf_we, last_byte;
  logic [OBJBUF_AW-1:0] count_q;
  logic [BUF_AW-1:0]    buf_waddr, buf_raddr;

  assign tick      = ~i_EMU_CLK6MPCEN_n;
  assign last_byte = (count_q == LAST_IDX);
  assign buf_we    = tick && (state_q == READ) && !i_OBJDMA_BUSACK_n;

  // Losing the grant in ADDR or READ falls back to REQ without committing the byte.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (trig_edge && i_OBJ_BUF_INIT_STOP_n) state_d = REQ;
      REQ:  if (!i_OBJDMA_BUSACK_n) state_d = ADDR;
      ADDR: state_d = i_OBJDMA_BUSACK_n ? REQ : READ;
      READ: begin
        if (i_OBJDMA_BUSACK_n) state_d = REQ;
        else if (last_byte)    state_d = DONE;
        else                   state_d = ADDR;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) begin
      state_q   <= IDLE;
      trig_prev <= 1'b0;
      trig_edge <= 1'b0;
      busrq_n_q <= 1'b1;
      rd_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      count_q   <= '0;
    end else if (tick) begin
      state_q   <= state_d;
      trig_prev <= i_DMA_TRIG;
      trig_edge <= i_DMA_TRIG & ~trig_prev;
      rd_n_q    <= ~((state_d == ADDR) || (state_d == READ));
      if ((state_q == IDLE) && (state_d == REQ)) begin
        busrq_n_q <= 1'b0;
        busy_q    <= 1'b1;
      end
      // Bus release, busy drop and bank swap all land on the DONE tick.
      if (state_q == DONE) begin
        busrq_n_q <= 1'b1;
        busy_q    <= 1'b0;
        count_q   <= '0;
      end else if (buf_we && !last_byte) begin
        count_q <= count_q + OBJBUF_AW'(1);
      end
    end
  end

`ifdef PSYCHIC5_OBJDMA_DBLBUF_EN
  logic disp_bank;

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n)                    disp_bank <= 1'b0;
    else if (tick && (state_q == DONE))   disp_bank <= ~disp_bank;
  end

  assign buf_waddr = {~disp_bank, count_q};
  assign buf_raddr = {disp_bank, i_BUF_RADDR};
`else
  assign buf_waddr = count_q;
  assign buf_raddr = i_BUF_RADDR;
`endif

  psychic5_objdma_buf #(
    .AW (BUF_AW)
  ) u_buf (
    .i_EMU_MCLK (i_EMU_MCLK),
    .wr_en      (buf_we),
    .wr_addr    (buf_waddr),
    .wr_data    (i_OBJDMA_DATA_READ_BUS),
    .rd_addr    (buf_raddr),
    .rd_data    (o_BUF_RDATA)
  );

  assign o_OBJDMA_ADDR_BUS  = P_BASE_ADDR + {{(OBJDMA_AW-OBJBUF_AW){1'b0}}, count_q};
  assign o_OBJDMA_BUSRQ_n   = busrq_n_q;
  assign o_OBJDMA_CTRL_RD_n = rd_n_q;
  assign o_OBJDMA_CTRL_WR_n = 1'b1;
  assign o_DMA_BUSY         = busy_q;

endmodule
